ext_pipe: RTL
=============

# ext_pipe

Parametrised, pipelined immediate/field extension unit for the CPU datapath. It replaces the fixed 5-bit zero-extender. It accepts a field of programmable length and produces a zero-extended, sign-extended or upper-placed (LUI-style) word of configurable width. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so the decode→execute boundary can stall without dropping operands.

## Interface
Parameters:
- `IN_W`, default 16: width of the input field bus.
- `OUT_W`, default 32: output word width. Must satisfy `OUT_W >= IN_W`.
- `LEN_W`, default `$clog2(IN_W+1)`: width of the length field.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset. **Synchronous, active-high.**
- `in_valid` input, 1 bit: the upstream beat is valid.
- `in_ready` output, 1 bit: the unit can accept a beat.
- `in_data` input, `IN_W` bits: raw field. Only bits `[in_len-1:0]` are significant.
- `in_len` input, `LEN_W` bits: number of significant low bits.
- `in_mode` input, 2 bits: extension mode.
  - 0 = ZERO
  - 1 = SIGN
  - 2 = HIGH
  - 3 = reserved
- `out_valid` output, 1 bit: output beat is valid.
- `out_ready` input, 1 bit: downstream accepts the beat.
- `out_data` output, `OUT_W` bits: extended result.
- `out_err` output, 1 bit: the beat had an illegal mode or length.

## Operation
- Beat accepted when `in_valid && in_ready`. Beat delivered when `out_valid && out_ready`.
- Length handling:
  - Effective length `L = min(in_len, IN_W)`.
  - Bits of `in_data` at positions ≥ L are masked to 0 before extension.
- ZERO mode: `out_data = {0, field[L-1:0]}`.
- SIGN mode:
  - Bits `[OUT_W-1:L]` are copies of `field[L-1]`.
  - L=1 with bit set gives all ones.
- HIGH mode: `out_data = field[L-1:0] << (OUT_W-L)`. Unused low bits are 0. Example: `L=16`, `OUT_W=32` gives `imm<<16`.
- Error cases (set `out_err=1`):
  - Mode 3: processed as ZERO.
  - `in_len == 0`: `out_data = 0`.
  - `in_len > IN_W`: clamped to IN_W.
- `out_err` travels with its beat; it is not sticky.
- Storage:
  - Output register (main) plus one skid register.
  - Order is strictly FIFO. No beat is dropped or duplicated.
- Simultaneous accept and deliver while main is full and skid is empty: main reloads with the new beat; skid stays empty.

## Timing
- Latency: 1 cycle. A beat accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 beat/cycle while `out_ready=1`.
- `in_ready` is registered: `in_ready = !skid_full`. It is not combinationally dependent on `out_ready`.
- When `out_ready` drops:
  - One more beat can still be accepted; it goes into skid.
  - `in_ready` deasserts the next cycle.
- When `out_ready` returns: the skid beat moves to main on the delivery edge, and `in_ready` reasserts the next cycle.
- `out_data`, `out_err` and `out_valid` are stable while `out_valid && !out_ready`.
- State: EMPTY, ONE (main full), TWO (main+skid full).
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without deliver.
  - ONE → EMPTY on deliver without accept.
  - TWO → ONE on deliver. No accept is possible in TWO.
- Reset values: `out_valid=0`, `out_data=0`, `out_err=0`, `in_ready=1` in the cycle after `rst`, state EMPTY.
- Reset mid-operation flushes both entries. Inputs during `rst=1` are ignored.

## Structure
- Shared package `ext_pkg`:
  - Mode constants `EXT_ZERO`, `EXT_SIGN`, `EXT_HIGH`, `EXT_RSVD`.
  - 2-bit `ext_mode_t` typedef.
- Combinational extension function in sub-module `ext_core`: parameters `IN_W` and `OUT_W`; inputs data, len, mode; outputs word and err.
- Top-level holds the skid buffer and FSM. `ext_core` is reusable unregistered elsewhere.

## Test plan
- Shamt: `IN_W=16`, `OUT_W=32`, `in_data=16'h001F`, `len=5`, ZERO → `32'h0000001F`, `err=0`, one cycle later.
- Sign: `in_data=16'h8000`, `len=16`, SIGN → `32'hFFFF8000`. `in_data=16'h0012`, `len=5`, SIGN → `32'hFFFFFFF2`.
- LUI: `in_data=16'h1234`, `len=16`, HIGH → `32'h12340000`. Mode 3 with `16'h00AB`, `len=8` → `32'h000000AB`, `err=1`.
- Backpressure: stream beats 1..6 with `out_ready` low on cycles 2–4.
  - All six are delivered in order.
  - `in_ready` drops exactly one cycle after the skid fills.
  - `out_data` is stable while stalled.
- Boundary lengths: `len=0` → 0 with `err=1`. `len=17` with `in_data=16'hFFFF` in SIGN → `32'hFFFFFFFF` with `err=1`.
- Reset with two beats buffered: `rst` for one cycle → next cycle `out_valid=0`, `in_ready=1`, and neither buffered beat ever appears.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the field-extension pipeline: extension modes and
// the skid-buffer occupancy states.
package ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO = 2'd0;
    localparam ext_mode_t EXT_SIGN = 2'd1;
    localparam ext_mode_t EXT_HIGH = 2'd2;
    localparam ext_mode_t EXT_RSVD = 2'd3;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_t;

endpackage

// File: rtl/ext_pipe_if.sv
// Handshake bundle between decode (master) and the extension pipeline (slave).
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int LEN_W = $clog2(IN_W + 1)
);
    import ext_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [LEN_W-1:0] in_len;
    ext_mode_t        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_len, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_len, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_core.sv
// Combinational field extender: zero, sign or upper-placed result from the
// low `len` bits of `data`. Usable unregistered outside the pipeline.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  data,
    input  logic [LEN_W-1:0] len,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] word,
    output logic             err
);

    localparam int SH_W = $clog2(OUT_W + 1);

    function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] rawLen);
        return (rawLen > LEN_W'(IN_W)) ? LEN_W'(IN_W) : rawLen;
    endfunction

    logic [LEN_W-1:0]        effLen;
    logic [IN_W-1:0]         fieldMasked;
    logic [SH_W-1:0]         highShamt;
    logic signed [OUT_W-1:0] highWord;
    logic signed [OUT_W-1:0] signWord;

    // Sign extension reuses the top-aligned word: an arithmetic shift back
    // down replicates field[L-1]; L=0 leaves an all-zero word.
    always_comb begin
        effLen      = clampLen(len);
        fieldMasked = data & ({IN_W{1'b1}} >> (LEN_W'(IN_W) - effLen));
        highShamt   = SH_W'(OUT_W) - SH_W'(effLen);
        highWord    = $signed(OUT_W'(fieldMasked) << highShamt);
        signWord    = highWord >>> highShamt;

        case (mode)
            EXT_SIGN: word = $unsigned(signWord);
            EXT_HIGH: word = $unsigned(highWord);
            default:  word = OUT_W'(fieldMasked);
        endcase

        err = (mode == EXT_RSVD) || (len == '0) || (len > LEN_W'(IN_W));
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered extension stage with a two-entry skid buffer so the
// decode/execute boundary can stall without losing operands.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input logic       clk,
    input logic       rst,
    ext_pipe_if.slave bus
);

    logic [OUT_W-1:0] coreWord_p0;
    logic             coreErr_p0;

    logic [OUT_W-1:0] mainData_p1;
    logic             mainErr_p1;
    logic [OUT_W-1:0] skidData_p1;
    logic             skidErr_p1;
    logic             inReady_p1;

    skid_state_t state;
    skid_state_t stateNext;
    logic        outValid;
    logic        accept;
    logic        deliver;
    logic        loadMain;
    logic        loadSkid;
    logic        mainFromSkid;

    ext_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .LEN_W(LEN_W)
    ) core (
        .data(bus.in_data),
        .len (bus.in_len),
        .mode(bus.in_mode),
        .word(coreWord_p0),
        .err (coreErr_p0)
    );

    assign outValid = (state != SKID_EMPTY);
    assign accept   = bus.in_valid && inReady_p1;
    assign deliver  = outValid && bus.out_ready;

    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    stateNext = SKID_ONE;
                    loadMain  = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && deliver) begin
                    loadMain = 1'b1;
                end else if (accept) begin
                    stateNext = SKID_TWO;
                    loadSkid  = 1'b1;
                end else if (deliver) begin
                    stateNext = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (deliver) begin
                    stateNext    = SKID_ONE;
                    mainFromSkid = 1'b1;
                end
            end
            default: stateNext = SKID_EMPTY;
        endcase
    end

    // p0 -> p1: extended word lands in main, or in skid when main is held
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SKID_EMPTY;
            inReady_p1  <= 1'b1;
            mainData_p1 <= '0;
            mainErr_p1  <= 1'b0;
        end else begin
            state      <= stateNext;
            inReady_p1 <= (stateNext != SKID_TWO);
            if (loadMain) begin
                mainData_p1 <= coreWord_p0;
                mainErr_p1  <= coreErr_p0;
            end else if (mainFromSkid) begin
                mainData_p1 <= skidData_p1;
                mainErr_p1  <= skidErr_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loadSkid) begin
            skidData_p1 <= coreWord_p0;
            skidErr_p1  <= coreErr_p0;
        end
    end

    assign bus.in_ready  = inReady_p1;
    assign bus.out_valid = outValid;
    assign bus.out_data  = mainData_p1;
    assign bus.out_err   = mainErr_p1;

endmodule
